// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the shared-memory arbiter, its two requesters and the block memory.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mem_port_arbiter_if #(
  parameter int LOG_SIZE = 10,
  parameter int WIDTH    = 128
);
  logic                in_h_req;
  logic                in_h_we;
  logic [LOG_SIZE-1:0] in_h_addr;
  logic [WIDTH-1:0]    in_h_wdata;
  logic                out_h_gnt;
  logic                out_h_err;
  logic                out_h_rvalid;
  logic [WIDTH-1:0]    out_h_rdata;

  logic                in_e_req;
  logic                in_e_we;
  logic [LOG_SIZE-1:0] in_e_addr;
  logic [WIDTH-1:0]    in_e_wdata;
  logic                out_e_gnt;
  logic                out_e_err;
  logic                out_e_rvalid;
  logic [WIDTH-1:0]    out_e_rdata;

  logic [LOG_SIZE-1:0] out_mem_address;
  logic [WIDTH-1:0]    out_mem_data;
  logic                out_mem_read_en;
  logic                out_mem_write_en;
  logic [WIDTH-1:0]    in_mem_data;
  logic                out_busy;

  modport slave (
    input  in_h_req, in_h_we, in_h_addr, in_h_wdata,
    output out_h_gnt, out_h_err, out_h_rvalid, out_h_rdata,
    input  in_e_req, in_e_we, in_e_addr, in_e_wdata,
    output out_e_gnt, out_e_err, out_e_rvalid, out_e_rdata,
    output out_mem_address, out_mem_data, out_mem_read_en, out_mem_write_en,
    input  in_mem_data,
    output out_busy
  );

  modport master (
    output in_h_req, in_h_we, in_h_addr, in_h_wdata,
    input  out_h_gnt, out_h_err, out_h_rvalid, out_h_rdata,
    output in_e_req, in_e_we, in_e_addr, in_e_wdata,
    input  out_e_gnt, out_e_err, out_e_rvalid, out_e_rdata,
    input  out_mem_address, out_mem_data, out_mem_read_en, out_mem_write_en,
    output in_mem_data,
    input  out_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin host/engine arbiter for a single-port block memory: checks each winning
// access, issues registered commands and routes read data back to its requester.
module mem_port_arbiter #(
  parameter int LOG_SIZE   = 10,
  parameter int SIZE       = 1024,
  parameter int BLOCKS     = 4,
  parameter int CELL_WIDTH = 32,
  parameter int WIDTH      = BLOCKS * CELL_WIDTH
) (
  input logic               in_clk,
  input logic               in_reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic HOST   = 1'b0;
  localparam logic ENGINE = 1'b1;
  localparam logic [LOG_SIZE:0] BLOCKS_EXT = (LOG_SIZE + 1)'(BLOCKS);
  localparam logic [LOG_SIZE:0] SIZE_EXT   = (LOG_SIZE + 1)'(SIZE);

  logic [1:0]          req;
  logic [1:0]          we;
  logic [1:0]          elig;
  logic [LOG_SIZE-1:0] addr [2];
  logic [WIDTH-1:0]    wdata [2];

  logic [1:0]          gnt_reg;
  logic [1:0]          err_reg;
  logic [1:0]          rvalid_reg;
  logic [WIDTH-1:0]    rdata_reg [2];
  logic [LOG_SIZE-1:0] mem_address_reg;
  logic [WIDTH-1:0]    mem_data_reg;
  logic                read_en_reg;
  logic                write_en_reg;
  logic                last_winner_reg;
  logic                p1_valid_reg;
  logic                p1_owner_reg;
  logic                p2_valid_reg;
  logic                p2_owner_reg;

  logic                win;
  logic                win_valid;
  logic                win_we;
  logic [LOG_SIZE-1:0] win_addr;
  logic [WIDTH-1:0]    win_wdata;
  logic [LOG_SIZE:0]   addr_end;
  logic                overrun;
  logic                protect;
  logic                legal;

  assign req      = {bus.in_e_req, bus.in_h_req};
  assign we       = {bus.in_e_we, bus.in_h_we};
  assign addr[0]  = bus.in_h_addr;
  assign addr[1]  = bus.in_e_addr;
  assign wdata[0] = bus.in_h_wdata;
  assign wdata[1] = bus.in_e_wdata;

  // A requester whose gnt/err is showing this cycle is still holding its old request.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = req[gi] & ~gnt_reg[gi] & ~err_reg[gi];
    end
  endgenerate

  always_comb begin
    win_valid = |elig;
    win       = (&elig) ? ~last_winner_reg : elig[1];
    win_we    = we[win];
    win_addr  = addr[win];
    win_wdata = wdata[win];
    addr_end  = {1'b0, win_addr} + BLOCKS_EXT;
    overrun   = addr_end > SIZE_EXT;
    protect   = (win == ENGINE) && win_we && ({1'b0, win_addr} < BLOCKS_EXT);
    legal     = win_valid & ~overrun & ~protect;
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      gnt_reg         <= '0;
      err_reg         <= '0;
      rvalid_reg      <= '0;
      rdata_reg[0]    <= '0;
      rdata_reg[1]    <= '0;
      mem_address_reg <= '0;
      mem_data_reg    <= '0;
      read_en_reg     <= 1'b0;
      write_en_reg    <= 1'b0;
      last_winner_reg <= ENGINE;
      p1_valid_reg    <= 1'b0;
      p1_owner_reg    <= HOST;
      p2_valid_reg    <= 1'b0;
      p2_owner_reg    <= HOST;
    end else begin
      gnt_reg      <= '0;
      err_reg      <= '0;
      rvalid_reg   <= '0;
      read_en_reg  <= 1'b0;
      write_en_reg <= 1'b0;
      if (legal) begin
        gnt_reg[win]    <= 1'b1;
        mem_address_reg <= win_addr;
        write_en_reg    <= win_we;
        read_en_reg     <= ~win_we;
        mem_data_reg    <= win_we ? win_wdata : '0;
        last_winner_reg <= win;
      end else if (win_valid) begin
        err_reg[win] <= 1'b1;
      end
      // Stage 2 lines up with the cycle the memory drives read data.
      p1_valid_reg <= legal & ~win_we;
      p1_owner_reg <= win;
      p2_valid_reg <= p1_valid_reg;
      p2_owner_reg <= p1_owner_reg;
      if (p2_valid_reg) begin
        rvalid_reg[p2_owner_reg] <= 1'b1;
        rdata_reg[p2_owner_reg]  <= bus.in_mem_data;
      end
    end
  end

  assign bus.out_h_gnt        = gnt_reg[0];
  assign bus.out_e_gnt        = gnt_reg[1];
  assign bus.out_h_err        = err_reg[0];
  assign bus.out_e_err        = err_reg[1];
  assign bus.out_h_rvalid     = rvalid_reg[0];
  assign bus.out_e_rvalid     = rvalid_reg[1];
  assign bus.out_h_rdata      = rdata_reg[0];
  assign bus.out_e_rdata      = rdata_reg[1];
  assign bus.out_mem_address  = mem_address_reg;
  assign bus.out_mem_data     = mem_data_reg;
  assign bus.out_mem_read_en  = read_en_reg;
  assign bus.out_mem_write_en = write_en_reg;
  assign bus.out_busy         = p1_valid_reg | p2_valid_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural registered-read memory attached.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter;
  localparam int LOG_SIZE   = 10;
  localparam int SIZE       = 1024;
  localparam int BLOCKS     = 4;
  localparam int CELL_WIDTH = 32;
  localparam int WIDTH      = 128;

  logic in_clk   = 1'b0;
  logic in_reset = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  always #5 in_clk = ~in_clk;

  mem_port_arbiter_if #(.LOG_SIZE(LOG_SIZE), .WIDTH(WIDTH)) bus ();

  mem_port_arbiter #(
    .LOG_SIZE(LOG_SIZE), .SIZE(SIZE), .BLOCKS(BLOCKS),
    .CELL_WIDTH(CELL_WIDTH), .WIDTH(WIDTH)
  ) dut (
    .in_clk  (in_clk),
    .in_reset(in_reset),
    .bus     (bus)
  );

  // Memory: commands execute on the edge ending their cycle, read data valid the next cycle.
  logic [31:0]      cells [SIZE];
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg = 1'b0;

  always @(posedge in_clk) begin
    rd_valid_reg <= bus.out_mem_read_en;
    if (bus.out_mem_write_en)
      for (int i = 0; i < BLOCKS; i++)
        cells[(int'(bus.out_mem_address) + i) % SIZE] <= bus.out_mem_data[i*32 +: 32];
    if (bus.out_mem_read_en)
      for (int i = 0; i < BLOCKS; i++)
        rd_data_reg[i*32 +: 32] <= cells[(int'(bus.out_mem_address) + i) % SIZE];
  end

  assign bus.in_mem_data = rd_valid_reg ? rd_data_reg : {4{32'hDEADBEEF}};

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  function automatic logic [WIDTH-1:0] pat_block(input int a);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < BLOCKS; i++) r[i*32 +: 32] = pat(a + i);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] b(input logic v);
    return {{(WIDTH-1){1'b0}}, v};
  endfunction

  task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                           input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic drive(input bit eng, input bit req, input bit we, input int addr,
                       input logic [WIDTH-1:0] wdata);
    if (eng) begin
      bus.in_e_req = req; bus.in_e_we = we;
      bus.in_e_addr = LOG_SIZE'(addr); bus.in_e_wdata = wdata;
    end else begin
      bus.in_h_req = req; bus.in_h_we = we;
      bus.in_h_addr = LOG_SIZE'(addr); bus.in_h_wdata = wdata;
    end
  endtask

  // One request from a single port: drive, check the gnt/err cycle, withdraw.
  task automatic issue(input bit eng, input bit we, input int addr,
                       input logic [WIDTH-1:0] wdata, input bit exp_err, input string tag);
    drive(eng, 1'b1, we, addr, wdata);
    step();
    check_val({tag, "_gnt"}, b(eng ? bus.out_e_gnt : bus.out_h_gnt), b(!exp_err));
    check_val({tag, "_err"}, b(eng ? bus.out_e_err : bus.out_h_err), b(exp_err));
    check_val({tag, "_wen"}, b(bus.out_mem_write_en), b(!exp_err && we));
    check_val({tag, "_ren"}, b(bus.out_mem_read_en), b(!exp_err && !we));
    if (!exp_err) begin
      check_val({tag, "_addr"}, WIDTH'(bus.out_mem_address), WIDTH'(addr));
      check_val({tag, "_data"}, bus.out_mem_data, we ? wdata : '0);
    end
    drive(eng, 1'b0, 1'b0, 0, '0);
    $display("%s: %s %s addr %0d", tag, eng ? "engine" : "host", we ? "wr" : "rd", addr);
  endtask

  // Continues from the gnt cycle of a read: rvalid must appear two cycles later.
  task automatic expect_rd(input bit eng, input logic [WIDTH-1:0] d, input string tag);
    step();
    check_val({tag, "_busy"}, b(bus.out_busy), b(1'b1));
    check_val({tag, "_early"}, b(eng ? bus.out_e_rvalid : bus.out_h_rvalid), b(1'b0));
    step();
    check_val({tag, "_rvalid"}, b(eng ? bus.out_e_rvalid : bus.out_h_rvalid), b(1'b1));
    check_val({tag, "_other"}, b(eng ? bus.out_h_rvalid : bus.out_e_rvalid), b(1'b0));
    check_val({tag, "_rdata"}, eng ? bus.out_e_rdata : bus.out_h_rdata, d);
    $display("%s: read return %h", tag, eng ? bus.out_e_rdata : bus.out_h_rdata);
  endtask

  task automatic do_reset();
    in_reset = 1'b0;
    step();
    in_reset = 1'b1;
    step();
  endtask

  localparam logic [WIDTH-1:0] DATA_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [WIDTH-1:0] DATA_B = 128'hFEEDFACE_13579BDF_2468ACE0_0BADF00D;

  initial begin
    int grants;
    int prev_gnt;
    for (int i = 0; i < SIZE; i++) cells[i] = pat(i);
    drive(1'b0, 1'b0, 1'b0, 0, '0);
    drive(1'b1, 1'b0, 1'b0, 0, '0);
    step();
    check_val("reset_gnt", b(bus.out_h_gnt | bus.out_e_gnt), b(1'b0));
    check_val("reset_en", b(bus.out_mem_read_en | bus.out_mem_write_en), b(1'b0));
    check_val("reset_busy", b(bus.out_busy), b(1'b0));
    check_val("reset_addr", WIDTH'(bus.out_mem_address), '0);
    in_reset = 1'b1;
    step();

    // Host write then read-back of the same block.
    issue(1'b0, 1'b1, 8, DATA_A, 1'b0, "h_wr8");
    step();
    issue(1'b0, 1'b0, 8, '0, 1'b0, "h_rd8");
    expect_rd(1'b0, DATA_A, "h_rd8");
    check_val("h_rd8_idle", b(bus.out_busy), b(1'b0));

    // Both ports reading continuously: grants alternate H,E and data returns to its owner.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 8, '0);
    drive(1'b1, 1'b1, 1'b0, 16, '0);
    for (int c = 1; c <= 9; c++) begin
      step();
      check_val($sformatf("rr_hgnt_c%0d", c), b(bus.out_h_gnt), b(c % 2 == 1 && c <= 5));
      check_val($sformatf("rr_egnt_c%0d", c), b(bus.out_e_gnt), b(c % 2 == 0 && c <= 6));
      check_val($sformatf("rr_hrv_c%0d", c), b(bus.out_h_rvalid),
                b(c % 2 == 1 && c >= 3 && c <= 7));
      check_val($sformatf("rr_erv_c%0d", c), b(bus.out_e_rvalid),
                b(c % 2 == 0 && c >= 4 && c <= 8));
      if (bus.out_h_rvalid) check_val($sformatf("rr_hdata_c%0d", c), bus.out_h_rdata, DATA_A);
      if (bus.out_e_rvalid) check_val($sformatf("rr_edata_c%0d", c), bus.out_e_rdata, pat_block(16));
      $display("rr cycle %0d: hgnt %0b egnt %0b hrv %0b erv %0b", c,
               bus.out_h_gnt, bus.out_e_gnt, bus.out_h_rvalid, bus.out_e_rvalid);
      if (c == 6) begin
        drive(1'b0, 1'b0, 1'b0, 0, '0);
        drive(1'b1, 1'b0, 1'b0, 0, '0);
      end
    end

    // Host alone holding req for 10 cycles: one grant every second cycle.
    grants = 0;
    prev_gnt = 0;
    drive(1'b0, 1'b1, 1'b0, 20, '0);
    for (int c = 1; c <= 11; c++) begin
      step();
      check_val($sformatf("solo_gnt_c%0d", c), b(bus.out_h_gnt), b(c % 2 == 1 && c <= 9));
      if (bus.out_h_gnt && prev_gnt == 1) check_val("solo_adjacent", b(1'b1), b(1'b0));
      if (bus.out_h_gnt) grants++;
      prev_gnt = int'(bus.out_h_gnt);
      if (c == 10) drive(1'b0, 1'b0, 1'b0, 0, '0);
    end
    check_val("solo_count", WIDTH'(grants), WIDTH'(5));
    $display("solo: %0d grants", grants);
    repeat (4) step();

    // Address overrun boundary.
    issue(1'b0, 1'b0, 1021, '0, 1'b1, "h_rd1021");
    for (int c = 0; c < 3; c++) begin
      step();
      check_val("h_rd1021_norv", b(bus.out_h_rvalid), b(1'b0));
      check_val("h_rd1021_nobusy", b(bus.out_busy), b(1'b0));
    end
    issue(1'b0, 1'b0, 1020, '0, 1'b0, "h_rd1020");
    expect_rd(1'b0, pat_block(1020), "h_rd1020");

    // Control block protection applies to engine writes only.
    issue(1'b1, 1'b1, 2, DATA_B, 1'b1, "e_wr2");
    step();
    issue(1'b1, 1'b0, 0, '0, 1'b0, "e_rd0");
    expect_rd(1'b1, pat_block(0), "e_rd0");
    issue(1'b0, 1'b1, 0, DATA_B, 1'b0, "h_wr0");
    step();
    issue(1'b0, 1'b0, 0, '0, 1'b0, "h_rd0");
    expect_rd(1'b0, DATA_B, "h_rd0");

    // Reset with a read in flight: everything clears at once and the read is lost.
    issue(1'b0, 1'b0, 8, '0, 1'b0, "h_rd_rst");
    step();
    in_reset = 1'b0;
    #1;
    check_val("rst_busy", b(bus.out_busy), b(1'b0));
    check_val("rst_ren", b(bus.out_mem_read_en), b(1'b0));
    check_val("rst_hrdata", bus.out_h_rdata, '0);
    check_val("rst_erdata", bus.out_e_rdata, '0);
    check_val("rst_addr", WIDTH'(bus.out_mem_address), '0);
    step();
    step();
    in_reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check_val("post_rst_norv", b(bus.out_h_rvalid), b(1'b0));
      check_val("post_rst_busy", b(bus.out_busy), b(1'b0));
    end
    drive(1'b0, 1'b1, 1'b0, 12, '0);
    drive(1'b1, 1'b1, 1'b0, 24, '0);
    step();
    check_val("tie_hgnt", b(bus.out_h_gnt), b(1'b1));
    check_val("tie_egnt", b(bus.out_e_gnt), b(1'b0));
    drive(1'b0, 1'b0, 1'b0, 0, '0);
    step();
    check_val("tie_egnt_next", b(bus.out_e_gnt), b(1'b1));
    drive(1'b1, 1'b0, 1'b0, 0, '0);
    $display("tie after reset: host first");
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the coprocessor's shared block memory: 4 x 32-bit cells per access, registered read, word 0 = config, word 1 = status.
- Shares the single memory port between the host interface and the compute engine using round-robin.
- Issues registered read and write commands and returns read data to the owning requester.
- Rejects accesses that overrun the array, and engine writes to the control block.

Parameters:
- LOG_SIZE, 10, memory address width in cells.
- SIZE, 1024, memory depth in cells.
- BLOCKS, 4, cells per access.
- CELL_WIDTH, 32, cell width.
- WIDTH, BLOCKS*CELL_WIDTH (128), data width of one access.

Ports:
- in_clk  input  1  clock; all state changes on the rising edge.
- in_reset  input  1  asynchronous, active-low reset.
- in_h_req  input  1  host request; held with in_h_we, in_h_addr and in_h_wdata stable until out_h_gnt or out_h_err.
- in_h_we  input  1  1 = write, 0 = read.
- in_h_addr  input  LOG_SIZE  base cell address.
- in_h_wdata  input  WIDTH  write data.
- out_h_gnt  output  1  one-cycle pulse: the request was issued to memory.
- out_h_err  output  1  one-cycle pulse: the request was rejected and nothing was issued.
- out_h_rvalid  output  1  one-cycle pulse: out_h_rdata is valid.
- out_h_rdata  output  WIDTH  read data.
- in_e_req, in_e_we, in_e_addr, in_e_wdata, out_e_gnt, out_e_err, out_e_rvalid, out_e_rdata: engine port, same directions, widths and meanings as the host port.
- out_mem_address  output  LOG_SIZE  memory address.
- out_mem_data  output  WIDTH  memory write data.
- out_mem_read_en  output  1  memory read enable.
- out_mem_write_en  output  1  memory write enable.
- in_mem_data  input  WIDTH  memory read data (high-Z when not reading).
- out_busy  output  1  a read is in flight in the pipeline.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0.
  - Read pipeline flushed; in-flight reads are discarded and produce no rvalid.
  - last_winner = engine, so the host wins the first tie.
- Eligibility: a requester is eligible in cycle N if its req=1 and its gnt/err is not high in cycle N. Consequence: one requester alone gets at most one access per 2 cycles; alternating requesters sustain 1 access per cycle.
- Arbitration, cycle N:
  - One eligible requester: it wins.
  - Both eligible: the requester that is not last_winner wins; last_winner updates to the winner.
  - Rejected requests do not update last_winner.
- Legality checks on the winner:
  - addr + BLOCKS > SIZE: rejected. Compute in LOG_SIZE+1 bits; no wrap-around.
  - Engine write with addr < BLOCKS: rejected (protects config/status).
  - Engine reads of that block are allowed. The host is unrestricted.
  - A rejected winner gets err=1 in cycle N+1, with read_en=write_en=0 in cycle N+1.
  - The losing requester is re-arbitrated in cycle N+1.
- Issue: for a legal winner, the rising edge ending cycle N registers:
  - gnt=1;
  - out_mem_address = addr;
  - out_mem_write_en = we;
  - out_mem_read_en = ~we;
  - out_mem_data = wdata for a write, else 0.
  - With no winner, both enables are 0 and address/data hold their previous values.
- Memory timing: the memory executes the command at the edge ending cycle N+1. Read data is present on in_mem_data during cycle N+2.
- Read return:
  - A 2-stage pipeline {valid, owner} tracks issued reads.
  - At the edge ending N+2, in_mem_data is registered into the owner's rdata, and the owner's rvalid=1 in cycle N+3.
  - Read latency: request seen in cycle N, data valid in cycle N+3.
  - rdata holds its value after rvalid; in_mem_data is sampled only for tracked reads.
- Ordering: commands reach memory in issue order. A read issued the cycle after a write to overlapping cells returns the new data.
- out_busy = OR of the pipeline valid bits.
- Dropping req: if req drops before grant, the request is withdrawn with no error.

Test Plan:
- Host write of 128'h0123..CDEF to addr 8 in cycle 0 -> gnt cycle 1, write_en cycle 1. Host read of addr 8 starting cycle 2 -> h_rvalid cycle 5 with identical data.
- Both requesters issue reads continuously from reset -> grants go H, E, H, E on consecutive cycles; each rvalid arrives 3 cycles after its request, returned to the correct port.
- Host alone holds req=1 for 10 cycles -> gnt pulses every 2nd cycle: 5 grants, never on adjacent cycles.
- Host read addr 1021 -> h_err pulse, no memory enable, no rvalid. Host read addr 1020 -> granted.
- Engine write addr 2 -> e_err. Engine read addr 0 -> granted, returns config+status. Host write addr 0 -> granted.
- Issue host read, assert in_reset low in cycle N+2 -> all outputs 0 immediately. After release, no rvalid appears, out_busy=0, and the first tie goes to the host.
